// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit LFSR generator: self-synchronises, predicts, counts mismatches.
// Optional per-bit error counting is enabled with LFSR_CHK_BITERR_EN.
module lfsr_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      data_in,
  input  logic             data_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_cnt
`endif
);

  // Handshake: data_in is consumed only on cycles where data_valid=1; there is no backpressure.
  localparam logic [1:0] S_HUNT_EMPTY = 2'd0;
  localparam logic [1:0] S_HUNT_SEED  = 2'd1;
  localparam logic [1:0] S_LOCKED     = 2'd2;

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_THRESH + 1);

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [1:0]         state, state_d;
  logic [15:0]        expected, expected_d;
  logic [MATCH_W-1:0] match, match_d;
  logic [MISS_W-1:0]  miss, miss_d;
  logic               err_hit;
  logic [CNT_W-1:0]   err_base, err_cnt_d;

  always_comb begin
    state_d    = state;
    expected_d = expected;
    match_d    = match;
    miss_d     = miss;
    err_hit    = 1'b0;
    if (data_valid) begin
      case (state)
        S_HUNT_EMPTY: begin
          // An all-zero word is the lock-up state and can never seed the predictor.
          if (data_in != 16'h0000) begin
            expected_d = nxt(data_in);
            match_d    = '0;
            state_d    = S_HUNT_SEED;
          end
        end
        S_HUNT_SEED: begin
          if (data_in == expected) begin
            expected_d = nxt(expected);
            match_d    = match + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_CNT)) state_d = S_LOCKED;
          end else if (data_in == 16'h0000) begin
            match_d = '0;
            state_d = S_HUNT_EMPTY;
          end else begin
            expected_d = nxt(data_in);
            match_d    = '0;
          end
        end
        S_LOCKED: begin
          // Free-running prediction: a corrupt word never reloads the predictor.
          expected_d = nxt(expected);
          if (data_in == expected) begin
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            miss_d  = miss + MISS_W'(1);
            if (miss_d == MISS_W'(LOSS_THRESH)) begin
              miss_d  = '0;
              match_d = '0;
              state_d = S_HUNT_EMPTY;
            end
          end
        end
        default: state_d = S_HUNT_EMPTY;
      endcase
    end
  end

  // Clear takes effect first so a same-cycle error leaves a count of one.
  assign err_base  = err_clr ? '0 : err_cnt;
  assign err_cnt_d = (err_hit && (err_base != '1)) ? err_base + CNT_W'(1) : err_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT_EMPTY;
      expected  <= '0;
      match     <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_d;
      expected  <= expected_d;
      match     <= match_d;
      miss      <= miss_d;
      locked    <= (state_d == S_LOCKED);
      err_pulse <= err_hit;
      err_cnt   <= err_cnt_d;
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  logic [CNT_W-1:0] bit_base, bit_cnt_d;
  logic [CNT_W+4:0] bit_sum;

  // Sum is widened so a saturating add of up to 16 never wraps, even for narrow counters.
  assign bit_base = err_clr ? '0 : bit_err_cnt;
  assign bit_sum  = {5'd0, bit_base} + {{CNT_W{1'b0}}, popcount16(data_in ^ expected)};
  always_comb begin
    bit_cnt_d = bit_base;
    if (err_hit) bit_cnt_d = (bit_sum[CNT_W+4:CNT_W] != 5'd0) ? '1 : bit_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_err_cnt <= '0;
    else        bit_err_cnt <= bit_cnt_d;
  end
`else
  // Without bit-error counting, err_cnt is the only statistic kept.
`endif

endmodule
